// File: rtl/c7bexc_arb.sv
// Writeback exception/interrupt arbiter: picks one event per retiring instruction,
// pulses except/ertn to CSR and holds the IFU redirect handshake.
// Optional: `define C7B_EXC_EXT_INTR_SYNC_EN for a 2-flop ext_intr synchroniser.
module c7bexc_arb #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_w,
    input  logic [31:0] pc_w,
    input  logic [31:0] addr_w,
    input  logic        ale_w,
    input  logic        ine_w,
    input  logic        sys_w,
    input  logic        brk_w,
    input  logic        ertn_w,
    input  logic        crmd_ie,
    input  logic [1:0]  estat_sis,
    input  logic        timer_intr,
    input  logic        ext_intr,
    input  logic        ifu_exc_ack,
    output logic        ext_intr_sync,
    output logic        except,
    output logic [5:0]  exccode,
    output logic [31:0] badv,
    output logic [31:0] era_pc,
    output logic        ertn,
    output logic        kill_w,
    output logic        exc_timeout
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [5:0] CODE_INT = 6'h00;
    localparam logic [5:0] CODE_INE = 6'h0D;
    localparam logic [5:0] CODE_SYS = 6'h0B;
    localparam logic [5:0] CODE_BRK = 6'h0C;
    localparam logic [5:0] CODE_ALE = 6'h09;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout_set;
    logic             int_pend, exc_ev, ertn_ev;
    logic [5:0]       code_sel;
    logic [31:0]      badv_sel;

`ifdef C7B_EXC_EXT_INTR_SYNC_EN
    logic ext_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_meta      <= 1'b0;
            ext_intr_sync <= 1'b0;
        end else begin
            ext_meta      <= ext_intr;
            ext_intr_sync <= ext_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) ext_intr_sync <= 1'b0;
        else     ext_intr_sync <= ext_intr;
    end
`endif

    assign int_pend = crmd_ie & |{ext_intr_sync, timer_intr, estat_sis};

    // Events are only taken in IDLE; BUSY squashes everything until IFU redirects.
    always_comb begin
        exc_ev   = 1'b0;
        ertn_ev  = 1'b0;
        code_sel = CODE_INT;
        badv_sel = pc_w;
        if (state == IDLE && valid_w) begin
            exc_ev = 1'b1;
            if (int_pend)   code_sel = CODE_INT;
            else if (ine_w) code_sel = CODE_INE;
            else if (sys_w) code_sel = CODE_SYS;
            else if (brk_w) code_sel = CODE_BRK;
            else if (ale_w) begin
                code_sel = CODE_ALE;
                badv_sel = addr_w;
            end else begin
                exc_ev  = 1'b0;
                ertn_ev = ertn_w;
            end
        end
    end

    assign kill_w = (state == BUSY) ? valid_w : exc_ev;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (exc_ev || ertn_ev) begin
                    state_nxt = BUSY;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (ifu_exc_ack) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            exc_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (timeout_set) exc_timeout <= 1'b1;
        end
    end

    // Cause/BADV/ERA hold their last committed values between events.
    always_ff @(posedge clk) begin
        if (rst) begin
            except  <= 1'b0;
            ertn    <= 1'b0;
            exccode <= '0;
            badv    <= '0;
            era_pc  <= '0;
        end else begin
            except <= exc_ev;
            ertn   <= ertn_ev;
            if (exc_ev) begin
                exccode <= code_sel;
                badv    <= badv_sel;
                era_pc  <= pc_w;
            end
        end
    end

endmodule

// File: doc/c7bexc_arb.md
Name: c7bexc_arb

Overview:
- Writeback-stage exception and interrupt arbiter.
- Collects per-instruction exception flags and pending interrupt sources for the instruction retiring at _w, picks one event by priority, and emits a single-cycle commit pulse with exccode, BADV value and ERA pc to the CSR block.
- Also issues the ertn pulse, synchronises the external interrupt line, and holds a redirect handshake with IFU so wrong-path retirements are squashed until the front end acknowledges.

Parameters:
- ACK_TIMEOUT, 16: max cycles in BUSY waiting for ifu_exc_ack before timeout error; must be ≥2.
- CNT_W, 5: width of the BUSY timeout counter; must satisfy 2^CNT_W > ACK_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- valid_w  in  1  instruction retiring at _w
- pc_w  in  32  pc of retiring instruction
- addr_w  in  32  memory address of retiring load/store
- ale_w  in  1  address misalign on retiring instruction
- ine_w  in  1  illegal instruction
- sys_w  in  1  syscall
- brk_w  in  1  break
- ertn_w  in  1  retiring instruction is ertn
- crmd_ie  in  1  global interrupt enable from CSR
- estat_sis  in  2  software interrupt bits from CSR
- timer_intr  in  1  timer interrupt pending from CSR
- ext_intr  in  1  raw asynchronous external interrupt
- ifu_exc_ack  in  1  IFU has redirected fetch
- ext_intr_sync  out  1  synchronised external interrupt to CSR
- except  out  1  exception/interrupt commit pulse
- exccode  out  6  cause code
- badv  out  32  BADV write value
- era_pc  out  32  ERA write value
- ertn  out  1  ertn commit pulse
- kill_w  out  1  suppress architectural writeback of the _w instruction
- exc_timeout  out  1  sticky error: ack not received

Behaviour:
- Reset (rst=1 at clk edge) values:
  - State is IDLE.
  - except=0, ertn=0, kill_w=0, exc_timeout=0.
  - exccode=0, badv=0, era_pc=0.
  - Synchroniser flops are 0, so ext_intr_sync=0.
  - Timeout counter is 0.
  - Reset mid-BUSY returns to IDLE; the pending ack is discarded.
- Outputs except, ertn, exccode, badv and era_pc are registered: they change exactly one cycle after the _w cycle that caused them.
- kill_w is combinational in the same cycle. It is 1 when:
  - state is BUSY and valid_w=1, or
  - state is IDLE and the retiring instruction takes an exception or interrupt.
- Interrupt pending: int_pend = crmd_ie & |{ext_intr_sync, timer_intr, estat_sis}.
- Event selection in IDLE with valid_w=1, first match wins:
  - int_pend → exccode 0x00
  - ine_w → 0x0D
  - sys_w → 0x0B
  - brk_w → 0x0C
  - ale_w → 0x09
  - otherwise, if ertn_w → ertn event
- An interrupt attaches to the retiring instruction: that instruction is killed and era_pc=pc_w, so it re-executes after ertn.
- badv = addr_w for ALE, otherwise pc_w.
- era_pc = pc_w for all exceptions.
- A kill_w'd instruction that carries ertn_w does not also pulse ertn.
- FSM:
  - IDLE --(except event or ertn event)--> BUSY. The counter loads 0.
  - BUSY: every valid_w is squashed (kill_w=1) and no new event is taken; exception flags, ertn_w and interrupts are ignored.
  - BUSY --(ifu_exc_ack)--> IDLE.
  - BUSY: the counter increments each cycle without ack. When the counter reaches ACK_TIMEOUT-1 with no ack, the block sets exc_timeout (sticky until rst) and returns to IDLE.
- Ack handling:
  - Ack may arrive at the earliest in the cycle the except/ertn pulse is high. An ack in that cycle is honoured: the block is back in IDLE the next cycle.
  - Ack while IDLE is ignored.
- Simultaneous events:
  - Multiple exception flags → single pulse with the priority winner.
  - Interrupt and ertn_w together → the interrupt wins; ertn is dropped with its instruction.
- valid_w=0 never raises an event, even with int_pend=1; the interrupt waits for the next retiring instruction.

Optional Feature:
- Macro: C7B_EXC_EXT_INTR_SYNC_EN.
- Defined: ext_intr passes through a 2-flop synchroniser; ext_intr_sync lags ext_intr by 2 cycles.
- Undefined: ext_intr is assumed already synchronous and passes through one register; latency is 1 cycle.

Test Plan:
- Reset: hold rst 2 cycles → all outputs 0, state IDLE; release with valid_w=1 and no flags → no except, kill_w=0.
- ALE: valid_w=1, ale_w=1, pc_w=0x1C000100, addr_w=0x00000203 → next cycle except=1 for 1 cycle, exccode=0x09, badv=0x00000203, era_pc=0x1C000100; kill_w=1 in the _w cycle.
- Priority: ine_w=1 and ale_w=1 together, crmd_ie=0 → exccode=0x0D, badv=pc_w; same with crmd_ie=1 and timer_intr=1 → exccode=0x00.
- Squash: after except, keep ack low 3 cycles with valid_w=1 and sys_w=1 → kill_w=1 each cycle, no second except pulse; ack → IDLE, next valid_w not killed.
- Timeout (ACK_TIMEOUT=16): trigger brk_w, never ack → exc_timeout=1 after 16 BUSY cycles, state back to IDLE, flag stays set until rst.
- Ext interrupt: crmd_ie=1, raise ext_intr → ext_intr_sync high after 2 cycles (1 without macro); the first valid_w after that gives except with exccode 0x00; ertn_w in the same cycle produces no ertn pulse.
